// File: rtl/sr_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sr_seq_pkg
// Purpose  : Shared op encodings, FSM states and counter width for the
//            set/reset bank sequencer.
// Revision : 1.0
// ============================================================================
package sr_seq_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SETTLE = 2'd2
  } state_t;

endpackage : sr_seq_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-input round-robin arbiter; priority flips only on contention.
// Revision : 1.0
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  logic r_prio_b;
  logic w_contend;

  assign w_contend = i_en && (i_req == 2'b11);

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      if (i_req == 2'b11) begin
        o_gnt = r_prio_b ? 2'b10 : 2'b01;
      end else begin
        o_gnt = i_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio_b <= 1'b0;
    end else if (w_contend) begin
      r_prio_b <= ~r_prio_b;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/sr_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sr_bank_sequencer
// Purpose  : Set/reset bit bank shared by two requesters with a settle window.
// Revision : 1.0
// ============================================================================
module sr_bank_sequencer
  import sr_seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int IDXW       = 3,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_a_valid,
  input  logic [1:0]       i_a_op,
  input  logic [IDXW-1:0]  i_a_idx,
  output logic             o_a_ready,
  input  logic             i_b_valid,
  input  logic [1:0]       i_b_op,
  input  logic [IDXW-1:0]  i_b_idx,
  output logic             o_b_ready,
  input  logic             i_clr_err,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_q_bar,
  output logic             o_done,
  output logic             o_err,
  output logic             o_err_flag,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] c_settle_last =
    (SETTLE_CYC > 0) ? CNT_W'(SETTLE_CYC - 1) : '0;
  localparam logic [IDXW:0]    c_width = (IDXW + 1)'(WIDTH);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_op;
  logic [IDXW-1:0]   r_idx;
  logic [WIDTH-1:0]  r_q;
  logic              r_done;
  logic              r_err;
  logic              r_err_flag;

  logic [1:0]        w_gnt;
  logic              w_acc;
  logic              w_ill;
  logic [WIDTH-1:0]  w_mask;
  logic [WIDTH-1:0]  w_q_nxt;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req ({i_b_valid, i_a_valid}),
    .i_en  (r_state == IDLE),
    .o_gnt (w_gnt)
  );

  assign o_a_ready = w_gnt[0];
  assign o_b_ready = w_gnt[1];
  assign w_acc     = |w_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_acc) w_state_nxt = APPLY;
      APPLY:   w_state_nxt = (SETTLE_CYC > 0) ? SETTLE : IDLE;
      SETTLE:  if (r_cnt == '0) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Loaded on entry to SETTLE so that SETTLE lasts exactly SETTLE_CYC cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == APPLY) begin
      r_cnt <= c_settle_last;
    end else if (r_state == SETTLE && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= OP_HOLD;
      r_idx <= '0;
    end else if (w_acc) begin
      r_op  <= w_gnt[1] ? i_b_op  : i_a_op;
      r_idx <= w_gnt[1] ? i_b_idx : i_a_idx;
    end
  end

  assign w_ill  = (r_op == OP_ILL) || ({1'b0, r_idx} >= c_width);
  assign w_mask = WIDTH'(1) << r_idx;

  always_comb begin
    w_q_nxt = r_q;
    if (!w_ill) begin
      unique case (r_op)
        OP_HOLD: w_q_nxt = r_q;
        OP_CLR:  w_q_nxt = r_q & ~w_mask;
        OP_SET:  w_q_nxt = r_q | w_mask;
        default: w_q_nxt = r_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q        <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_flag <= 1'b0;
    end else begin
      r_done <= (r_state == APPLY);
      r_err  <= (r_state == APPLY) && w_ill;
      if (r_state == APPLY) begin
        r_q <= w_q_nxt;
      end
      // A clear that coincides with the error pulse is ignored so the set wins.
      if (r_state == APPLY && w_ill) begin
        r_err_flag <= 1'b1;
      end else if (i_clr_err && !r_err) begin
        r_err_flag <= 1'b0;
      end
    end
  end

  assign o_q        = r_q;
  assign o_q_bar    = ~r_q;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_err_flag = r_err_flag;
  assign o_busy     = (r_state != IDLE);

endmodule : sr_bank_sequencer
`default_nettype wire
